// File: rtl/jump_redirect_ctrl.sv
// PC-redirect controller: arbitrates J/JAL (ID) against JR and taken branches (EX),
// holds the pipeline while a JR waits for R31, and drives registered PC-mux, flush and stall controls.
module jump_redirect_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [25:0]       id_imm26,
  input  logic              ex_jr,
  input  logic [ADDR_W-1:0] ex_r31,
  input  logic              r31_pending,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] target,
  output logic              flush_if,
  output logic              flush_id,
  output logic              stall,
  output logic              wait_err,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_JIMM = 2'd1;
  localparam logic [1:0] SEL_JR   = 2'd2;
  localparam logic [1:0] SEL_BR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JR_WAIT = 2'd1,
    SHADOW  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic [1:0]          sel_nxt;
  logic [ADDR_W-1:0]   target_nxt;
  logic                flush_if_nxt, flush_id_nxt, stall_nxt, err_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                id_jump;

  assign id_jump = id_valid && (id_opcode == 6'b000010 || id_opcode == 6'b000011);

  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    sel_nxt      = SEL_SEQ;
    target_nxt   = '0;
    flush_if_nxt = 1'b0;
    flush_id_nxt = 1'b0;
    stall_nxt    = 1'b0;
    err_nxt      = wait_err;

    unique case (state)
      IDLE: begin
        // EX requests outrank ID: an older instruction's redirect squashes the ID jump anyway
        if (ex_jr) begin
          if (r31_pending) begin
            state_nxt = JR_WAIT;
            stall_nxt = 1'b1;
            wcnt_nxt  = WCNT_W'(1);
          end else begin
            sel_nxt      = SEL_JR;
            target_nxt   = ex_r31;
            flush_if_nxt = 1'b1;
            flush_id_nxt = 1'b1;
            state_nxt    = SHADOW;
          end
        end else if (ex_br_taken) begin
          sel_nxt      = SEL_BR;
          target_nxt   = ex_br_target;
          flush_if_nxt = 1'b1;
          flush_id_nxt = 1'b1;
          state_nxt    = SHADOW;
        end else if (id_jump) begin
          sel_nxt      = SEL_JIMM;
          target_nxt   = ADDR_W'(id_imm26);
          flush_if_nxt = 1'b1;
        end
      end

      JR_WAIT: begin
        if (!r31_pending || wcnt >= WCNT_W'(WAIT_MAX)) begin
          // On timeout the redirect still goes out with whatever R31 is visible now
          if (r31_pending) err_nxt = 1'b1;
          sel_nxt      = SEL_JR;
          target_nxt   = ex_r31;
          flush_if_nxt = 1'b1;
          flush_id_nxt = 1'b1;
          wcnt_nxt     = '0;
          state_nxt    = SHADOW;
        end else begin
          stall_nxt = 1'b1;
          wcnt_nxt  = wcnt + WCNT_W'(1);
        end
      end

      SHADOW: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_nxt = redirect_cnt;
    if (sel_nxt != SEL_SEQ && redirect_cnt != {CNT_W{1'b1}})
      cnt_nxt = redirect_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wcnt         <= '0;
      pc_sel       <= SEL_SEQ;
      target       <= '0;
      flush_if     <= 1'b0;
      flush_id     <= 1'b0;
      stall        <= 1'b0;
      wait_err     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_nxt;
      wcnt         <= wcnt_nxt;
      pc_sel       <= sel_nxt;
      target       <= target_nxt;
      flush_if     <= flush_if_nxt;
      flush_id     <= flush_id_nxt;
      stall        <= stall_nxt;
      wait_err     <= err_nxt;
      redirect_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl: J/JR/branch redirects, JR stall window, timeout, priority, reset, saturation.
module tb_jump_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [25:0]       id_imm26;
  logic              ex_jr;
  logic [ADDR_W-1:0] ex_r31;
  logic              r31_pending;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] target;
  logic              flush_if, flush_id, stall, wait_err;
  logic [CNT_W-1:0]  redirect_cnt;

  int checks = 0;
  int errors = 0;

  jump_redirect_ctrl #(.ADDR_W(ADDR_W), .WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_imm26(id_imm26),
    .ex_jr(ex_jr), .ex_r31(ex_r31), .r31_pending(r31_pending),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .pc_sel(pc_sel), .target(target), .flush_if(flush_if), .flush_id(flush_id),
    .stall(stall), .wait_err(wait_err), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_opcode = 0; id_imm26 = 0;
    ex_jr = 0; ex_r31 = 0; r31_pending = 0;
    ex_br_taken = 0; ex_br_target = 0;
  endtask

  task automatic check_out(input string tag, input logic [1:0] sel, input logic [31:0] tgt,
                           input logic fi, input logic fd, input logic st);
    check({tag, ".pc_sel"}, 64'(pc_sel), 64'(sel));
    check({tag, ".target"}, 64'(target), 64'(tgt));
    check({tag, ".flush_if"}, 64'(flush_if), 64'(fi));
    check({tag, ".flush_id"}, 64'(flush_id), 64'(fd));
    check({tag, ".stall"}, 64'(stall), 64'(st));
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    check_out("reset", 2'd0, 32'h0, 0, 0, 0);
    check("reset.wait_err", 64'(wait_err), 64'd0);
    check("reset.cnt", 64'(redirect_cnt), 64'd0);
    rst = 0;
    step();

    // J in ID
    id_valid = 1; id_opcode = 6'b000010; id_imm26 = 26'h40;
    step();
    check_out("j", 2'd1, 32'h40, 1, 0, 0);
    check("j.cnt", 64'(redirect_cnt), 64'd1);
    idle_inputs();
    step();
    check_out("j_hold1", 2'd0, 32'h0, 0, 0, 0);

    // JR without hazard, then JAL in ID during SHADOW is dropped
    ex_jr = 1; ex_r31 = 32'h2C;
    step();
    check_out("jr", 2'd2, 32'h2C, 1, 1, 0);
    check("jr.cnt", 64'(redirect_cnt), 64'd2);
    idle_inputs();
    id_valid = 1; id_opcode = 6'b000011; id_imm26 = 26'h80;
    step();
    check_out("shadow", 2'd0, 32'h0, 0, 0, 0);
    check("shadow.cnt", 64'(redirect_cnt), 64'd2);
    idle_inputs();
    step();

    // JR with R31 pending for two cycles
    ex_jr = 1; r31_pending = 1; ex_r31 = 32'h111;
    step();
    check_out("hz1", 2'd0, 32'h0, 0, 0, 1);
    step();
    check_out("hz2", 2'd0, 32'h0, 0, 0, 1);
    r31_pending = 0; ex_r31 = 32'h200;
    step();
    check_out("hz_rel", 2'd2, 32'h200, 1, 1, 0);
    check("hz.wait_err", 64'(wait_err), 64'd0);
    check("hz.cnt", 64'(redirect_cnt), 64'd3);
    idle_inputs();
    step();
    check_out("hz_after", 2'd0, 32'h0, 0, 0, 0);

    // Timeout: pending never drops
    ex_jr = 1; r31_pending = 1; ex_r31 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("to_stall%0d", i), 2'd0, 32'h0, 0, 0, 1);
      check($sformatf("to_err%0d", i), 64'(wait_err), 64'd0);
    end
    step();
    check_out("to_redir", 2'd2, 32'h300, 1, 1, 0);
    check("to.wait_err", 64'(wait_err), 64'd1);
    check("to.cnt", 64'(redirect_cnt), 64'd4);
    idle_inputs();
    step(); step(); step();
    check("to.sticky", 64'(wait_err), 64'd1);

    // Branch beats J in ID
    ex_br_taken = 1; ex_br_target = 32'h100;
    id_valid = 1; id_opcode = 6'b000010; id_imm26 = 26'h55;
    step();
    check_out("br", 2'd3, 32'h100, 1, 1, 0);
    check("br.cnt", 64'(redirect_cnt), 64'd5);
    idle_inputs();
    step(); step();
    // JR beats branch
    ex_jr = 1; ex_r31 = 32'h44; ex_br_taken = 1; ex_br_target = 32'h100;
    step();
    check_out("jr_vs_br", 2'd2, 32'h44, 1, 1, 0);
    check("jr_vs_br.cnt", 64'(redirect_cnt), 64'd6);
    idle_inputs();
    step(); step();

    // Asynchronous reset while in JR_WAIT
    ex_jr = 1; r31_pending = 1; ex_r31 = 32'h500;
    step();
    check("rstmid.pre_stall", 64'(stall), 64'd1);
    #2 rst = 1;
    #1;
    check_out("rstmid", 2'd0, 32'h0, 0, 0, 0);
    check("rstmid.wait_err", 64'(wait_err), 64'd0);
    check("rstmid.cnt", 64'(redirect_cnt), 64'd0);
    step();
    rst = 0;
    idle_inputs();
    id_valid = 1; id_opcode = 6'b000010; id_imm26 = 26'h3FF_FFFF;
    step();
    check_out("post_rst_j", 2'd1, 32'h03FF_FFFF, 1, 0, 0);
    check("post_rst.cnt", 64'(redirect_cnt), 64'd1);

    // Saturation: keep issuing J redirects every cycle
    id_imm26 = 26'h10;
    repeat (65539) @(posedge clk);
    #1;
    check("sat.cnt", 64'(redirect_cnt), 64'hFFFF);
    check("sat.pc_sel", 64'(pc_sel), 64'd1);
    idle_inputs();
    step();
    check("sat.hold", 64'(redirect_cnt), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
- Central PC-redirect controller for the 5-stage pipeline.
- Arbitrates redirect requests: J/JAL decoded in ID, JR and taken branches resolved in EX.
- Sequences the stall window for a JR whose R31 source is still in flight, and drives PC-mux select, registered target, flush and stall controls.
- Sits between the decode/EX resolution logic and the PC/IF-ID/ID-EX pipeline registers.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- WAIT_MAX, 4, maximum JR_WAIT cycles before a forced redirect with error flag.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  6  ID opcode field [31:26].
- id_imm26  in  26  ID jump index [25:0].
- ex_jr  in  1  EX holds JR (rtype & funct 6'b001000).
- ex_r31  in  ADDR_W  forwarded R31 value in EX.
- r31_pending  in  1  an older in-flight instruction will write R31, value not yet forwardable.
- ex_br_taken  in  1  EX branch resolved taken.
- ex_br_target  in  ADDR_W  EX branch target.
- pc_sel  out  2  0 = sequential, 1 = jump imm, 2 = JR, 3 = branch.
- target  out  ADDR_W  redirect address, valid when pc_sel != 0.
- flush_if  out  1  squash IF/ID register.
- flush_id  out  1  squash ID/EX register.
- stall  out  1  hold PC, IF/ID and ID/EX; EX is frozen.
- wait_err  out  1  sticky: JR_WAIT timed out.
- redirect_cnt  out  CNT_W  saturating count of issued redirects.

Behaviour:
- Reset (async, any state): state = IDLE; pc_sel = 0; target = 0; flush_if/flush_id/stall = 0; wait_err = 0; redirect_cnt = 0; wait counter = 0.
- All outputs are registered. A request sampled at edge N produces pc_sel/target/flush at edge N+1, held exactly one cycle.
- States:
  - IDLE: evaluate requests in priority order ex_jr > ex_br_taken > ID jump. Simultaneous ex_jr and ex_br_taken is illegal; JR wins.
  - JR_WAIT: stall = 1 every cycle; no redirect issued; ID requests ignored.
  - SHADOW: one cycle after any EX redirect; ID requests ignored because ID holds wrong-path work already flushed. Returns to IDLE.
- IDLE, ex_jr & r31_pending: go to JR_WAIT; stall = 1 next cycle; wait counter = 1.
- IDLE, ex_jr & !r31_pending: pc_sel = 2; target = ex_r31; flush_if = flush_id = 1; go to SHADOW.
- IDLE, ex_br_taken: pc_sel = 3; target = ex_br_target; flush_if = flush_id = 1; go to SHADOW.
- IDLE, id_valid & opcode 000010/000011, no EX request: pc_sel = 1; target = zero-extended id_imm26; flush_if = 1, flush_id = 0; stay in IDLE.
- IDLE, no request: pc_sel = 0, flushes low.
- JR_WAIT, r31_pending falls: issue the JR redirect on the next edge using ex_r31 sampled that cycle; stall = 0; go to SHADOW.
- JR_WAIT, wait counter reaches WAIT_MAX with r31_pending still high: set wait_err (sticky until rst); issue the JR redirect with the current ex_r31; go to SHADOW.
- EX-stage inputs are stable during stall, since EX is frozen.
- redirect_cnt increments once per issued redirect (pc_sel != 0) and saturates at all-ones.
- stall and a redirect are never asserted in the same cycle.

Test Plan:
- J in ID: opcode 000010, imm26 0x0000040 → next cycle pc_sel = 1, target = 0x00000040, flush_if = 1, flush_id = 0, redirect_cnt = 1.
- JR no hazard: ex_jr = 1, r31_pending = 0, ex_r31 = 0x2C → pc_sel = 2, target = 0x2C, both flushes = 1; a J in ID the following cycle is ignored (SHADOW).
- JR hazard: ex_jr = 1, r31_pending high for 2 cycles → stall = 1 for 2 cycles, then pc_sel = 2 with target = ex_r31 from the release cycle; wait_err = 0.
- Timeout: r31_pending held high → stall for WAIT_MAX = 4 cycles, then wait_err = 1 and pc_sel = 2; wait_err stays 1 until rst.
- Priority: ex_br_taken (target 0x100) and J in ID in the same cycle → pc_sel = 3, target = 0x100, J dropped; ex_jr with ex_br_taken → pc_sel = 2.
- Reset mid-JR_WAIT: assert rst asynchronously → all outputs 0 immediately, state IDLE; saturation check: 2^CNT_W + 3 redirects → redirect_cnt = 0xFFFF.
